// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
  localparam int DEF_WIDTH_N = 8;
  localparam int DEF_WIDTH_D = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [DEF_WIDTH_N-1:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract D if it fits.
module div_restore_step #(
  parameter int WIDTH_D = 4
) (
  input  logic [WIDTH_D-1:0] r,
  input  logic               dbit,
  input  logic [WIDTH_D-1:0] d,
  output logic [WIDTH_D-1:0] r_next,
  output logic               q_bit
);
  // One extra bit so the compare never overflows; the result is always < d.
  logic [WIDTH_D:0] r_ext;

  assign r_ext  = {r, dbit};
  assign q_bit  = (r_ext >= {1'b0, d});
  assign r_next = q_bit ? WIDTH_D'(r_ext - {1'b0, d}) : WIDTH_D'(r_ext);
endmodule

// File: rtl/seq_divider_n_by_d.sv
// Sequential restoring divider N/D with valid/ready on both sides, one bit per clock.
// Optional reconstruction check Q*D+R==N enabled by DIVIDER_SELF_CHECK_EN.
module seq_divider_n_by_d import div_pkg::*; #(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero,
  output logic               check_err
);
  localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  state_t             state, state_nxt;
  logic [WIDTH_N-1:0] q_q, q_nxt;
  logic [WIDTH_D-1:0] r_q, r_nxt, d_q;
  logic [CW-1:0]      cnt;
  logic               q_bit, dbz_q, last;

  assign last = (cnt == CW'(WIDTH_N - 1));

  div_restore_step #(.WIDTH_D(WIDTH_D)) u_step (
    .r      (r_q),
    .dbit   (q_q[WIDTH_N-1]),
    .d      (d_q),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  // Q doubles as the dividend shift register: MSB feeds the step, LSB takes the new quotient bit.
  assign q_nxt = (q_q << 1) | WIDTH_N'(q_bit);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (divisor != '0) ? BUSY : DONE;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt   <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d_q   <= divisor;
          r_q   <= '0;
          cnt   <= '0;
          dbz_q <= (divisor == '0);
          q_q   <= (divisor != '0) ? dividend : {WIDTH_N{DIV_ZERO_Q[0]}};
        end
        BUSY: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end

  // Results are only visible in DONE so a partial quotient never leaks out.
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = out_valid ? q_q : '0;
  assign remainder   = out_valid ? r_q : '0;
  assign div_by_zero = out_valid & dbz_q;

`ifdef DIVIDER_SELF_CHECK_EN
  localparam int EW = WIDTH_N + WIDTH_D;
  logic [WIDTH_N-1:0] n_q;
  logic [EW-1:0]      recon;
  logic               chk_q;

  assign recon = EW'(q_nxt) * EW'(d_q) + EW'(r_nxt);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n_q   <= '0;
      chk_q <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid) begin n_q <= dividend; chk_q <= 1'b0; end
        BUSY:    if (last) chk_q <= (recon != EW'(n_q));
        DONE:    if (out_ready) chk_q <= 1'b0;
        default: ;
      endcase
    end

  assign check_err = out_valid & chk_q;
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider_n_by_d.sv
// Directed table plus corner sequences and an exhaustive sweep for seq_divider_n_by_d.
module tb_seq_divider_n_by_d;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       check_err;

  int checks = 0;
  int errors = 0;

  seq_divider_n_by_d dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .check_err(check_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Present one operand pair when idle, then wait (bounded) for out_valid.
  task automatic do_div(input logic [7:0] n, input logic [3:0] d, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    in_valid = 1'b1; dividend = n; divisor = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    int   lat;
    int   stall;
    logic [7:0] eq;
    logic [3:0] er;

    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
    vecs[1] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 8};
    vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8};
    vecs[3] = '{8'd100, 4'd0,  8'hFF,  4'd0, 1'b1, 0};
    vecs[4] = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8};
    vecs[5] = '{8'd173, 4'd1,  8'd173, 4'd0, 1'b0, 8};
    vecs[6] = '{8'd173, 4'd13, 8'd13,  4'd4, 1'b0, 8};
    vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
    vecs[8] = '{8'd128, 4'd3,  8'd42,  4'd2, 1'b0, 8};
    vecs[9] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 8};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst div_by_zero", div_by_zero, 0);
    chk("rst check_err", check_err, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_div(vecs[i].n, vecs[i].d, lat);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d div_by_zero", i), div_by_zero, vecs[i].z);
      chk($sformatf("vec%0d check_err", i), check_err, 0);
      release_result();
      chk($sformatf("vec%0d in_ready after transfer", i), in_ready, 1);
      chk($sformatf("vec%0d out_valid after transfer", i), out_valid, 0);
    end

    // Backpressure on 255/1 with stray in_valid pulses during BUSY and DONE
    @(negedge clk);
    in_valid = 1'b1; dividend = 8'd255; divisor = 4'd1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp in_ready busy", in_ready, 0);
    in_valid = 1'b1; dividend = 8'd10; divisor = 4'd3;
    @(negedge clk); in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("bp reached done", out_valid, 1);
    in_valid = 1'b1; dividend = 8'd9; divisor = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d", c), {out_valid, in_ready, quotient, remainder}, {1'b1, 1'b0, 8'd255, 4'd0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp in_ready in transfer cycle", in_ready, 0);
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp in_ready after transfer", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("bp stray op not stored", {out_valid, in_ready}, 2'b01);

    // Reset asserted three cycles into a division
    @(negedge clk);
    in_valid = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort quotient", quotient, 0);
    @(negedge clk); rst = 1'b0;
    do_div(8'd50, 4'd6, lat);
    chk("post-reset latency", lat, 8);
    chk("post-reset 50/6", {quotient, remainder, div_by_zero}, {8'd8, 4'd2, 1'b0});
    release_result();

    // Exhaustive sweep with random output stalls
    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        eq = (d == 0) ? 8'hFF : 8'(n / d);
        er = (d == 0) ? 4'd0  : 4'(n % d);
        do_div(8'(n), 4'(d), lat);
        chk($sformatf("sweep %0d/%0d latency", n, d), lat, (d == 0) ? 0 : 8);
        stall = $urandom_range(0, 2);
        repeat (stall) @(posedge clk);
        #1;
        chk($sformatf("sweep %0d/%0d result", n, d),
            {out_valid, quotient, remainder, div_by_zero, check_err},
            {1'b1, eq, er, (d == 0), 1'b0});
        release_result();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
